// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, frame width and baud-divider helper,
// used by both the receiver and the transmitter.
package uart_pkg;

    localparam int DATA_BITS          = 8;
    localparam int OVERSAMPLE_DEFAULT = 16;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE  = 3'd0;
    localparam uart_state_t ST_START = 3'd1;
    localparam uart_state_t ST_DATA  = 3'd2;
    localparam uart_state_t ST_STOP  = 3'd3;
    localparam uart_state_t ST_BREAK = 3'd4;

    function automatic int clks_per_tick(input longint clk_freq, input longint baud_rate,
                                         input int oversample);
        return int'(clk_freq / (baud_rate * longint'(oversample)));
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every CLKS_PER_TICK clocks.
// restart zeroes the phase so the first tick lands CLKS_PER_TICK cycles later.
module uart_baud_tick #(
    parameter int CLKS_PER_TICK = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_TICK - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = 1'b0;
        cnt_d = cnt_q + CW'(1);
        if (restart) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
            tick  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: oversampled, 3-sample majority vote per bit, one-entry
// holding register with valid/ready handshake and sticky framing/overrun flags.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 overrun_err,
    input  logic                 clear_err
);

    localparam int CLKS_PER_TICK = clks_per_tick(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] SAMP_A  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] SAMP_B  = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] RESOLVE = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] LAST_T  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_B  = BW'(DATA_BITS - 1);

    generate
        if (CLKS_PER_TICK < 1) begin : g_bad_rate
            $error("uart_receiver: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE");
        end
        if ((OVERSAMPLE % 2 != 0) || (OVERSAMPLE < 8)) begin : g_bad_os
            $error("uart_receiver: OVERSAMPLE must be even and >= 8");
        end
    endgenerate

    logic                 rx_meta_q, rx_s_q;
    uart_state_t          state_q, state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 oerr_q, oerr_d;
    logic                 tick, restart, vote, resolve, boundary, deliver, ferr_set, oerr_set;

    assign restart = (state_q == ST_IDLE) && !rx_s_q;

    uart_baud_tick #(.CLKS_PER_TICK(CLKS_PER_TICK)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .restart(restart),
        .tick   (tick)
    );

    assign vote     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
    assign resolve  = tick && (tick_cnt_q == RESOLVE);
    assign boundary = tick && (tick_cnt_q == LAST_T);

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        samp_d     = samp_q;
        shreg_d    = shreg_q;
        deliver    = 1'b0;
        ferr_set   = 1'b0;

        if (tick && tick_cnt_q == SAMP_A) samp_d[0] = rx_s_q;
        if (tick && tick_cnt_q == SAMP_B) samp_d[1] = rx_s_q;
        if (tick) tick_cnt_d = boundary ? '0 : tick_cnt_q + TW'(1);

        case (state_q)
            ST_IDLE: begin
                tick_cnt_d = '0;
                if (!rx_s_q) state_d = ST_START;
            end
            ST_START: begin
                // A high majority at mid-start means the falling edge was noise.
                if (resolve && vote) begin
                    state_d = ST_IDLE;
                end else if (boundary) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (resolve) shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
                if (boundary) begin
                    if (bit_idx_q == LAST_B) state_d = ST_STOP;
                    else                     bit_idx_d = bit_idx_q + BW'(1);
                end
            end
            ST_STOP: begin
                if (resolve) begin
                    if (vote) begin
                        deliver = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (rx_s_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A delivery may reuse the slot being drained by a same-cycle handshake.
    always_comb begin
        data_d   = data_q;
        valid_d  = valid_q;
        oerr_set = 1'b0;
        if (deliver) begin
            if (!valid_q || rx_ready) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                oerr_set = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
        ferr_d = ferr_set ? 1'b1 : (clear_err ? 1'b0 : ferr_q);
        oerr_d = oerr_set ? 1'b1 : (clear_err ? 1'b0 : oerr_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            samp_q     <= '0;
            shreg_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            oerr_q     <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_s_q     <= rx_meta_q;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            samp_q     <= samp_d;
            shreg_q    <= shreg_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            oerr_q     <= oerr_d;
        end
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign frame_err   = ferr_q;
    assign overrun_err = oerr_q;
    assign rx_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: frame-level event model checked every cycle,
// plus literal checks at the end of each scenario.
module tb_uart_receiver;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 10_000;
    localparam int OS       = 16;
    localparam int CPT      = CLK_FREQ / (BAUD * OS);
    localparam int BITCLK   = CPT * OS;
    // 2 sync flops, the stop bit's resolve tick (tick number 9*OS+OS/2+2 after
    // the restart), then 1 clock to register the result.
    localparam int LAT      = 2 + CPT * (9 * OS + OS / 2 + 2) + 1;

    localparam int EV_NONE = 0;
    localparam int EV_DATA = 1;
    localparam int EV_FERR = 2;

    logic       clk = 1'b0;
    logic       reset, rx, rx_ready, clear_err;
    logic [7:0] rx_data;
    logic       rx_valid, rx_busy, frame_err, overrun_err;

    uart_receiver #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .overrun_err(overrun_err),
        .clear_err  (clear_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       cyc;
        int       kind;
        logic [7:0] data;
    } ev_t;

    ev_t        evq[$];
    ev_t        ev;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_miss = 0;
    logic       m_valid = 1'b0, m_ferr = 1'b0, m_oerr = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       s_rdy, s_clr, s_dlv, s_fset, s_oset;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Frame-level model: holding register and sticky flags updated on each edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            s_rdy  = rx_ready;
            s_clr  = clear_err;
            s_dlv  = 1'b0;
            s_fset = 1'b0;
            s_oset = 1'b0;
            if (reset) begin
                m_valid = 1'b0; m_ferr = 1'b0; m_oerr = 1'b0; m_data = 8'h00;
                evq.delete();
            end else begin
                if (evq.size() > 0 && evq[0].cyc <= cyc) begin
                    ev = evq.pop_front();
                    if (ev.kind == EV_FERR) s_fset = 1'b1;
                    else                    s_dlv  = 1'b1;
                end
                if (s_dlv) begin
                    if (!m_valid || s_rdy) begin
                        m_data  = ev.data;
                        m_valid = 1'b1;
                    end else begin
                        s_oset = 1'b1;
                    end
                end else if (m_valid && s_rdy) begin
                    m_valid = 1'b0;
                end
                if (s_fset)     m_ferr = 1'b1;
                else if (s_clr) m_ferr = 1'b0;
                if (s_oset)     m_oerr = 1'b1;
                else if (s_clr) m_oerr = 1'b0;
            end
            #1;
            if (!reset) begin
                check("cyc_valid", {7'd0, rx_valid}, {7'd0, m_valid});
                check("cyc_frame_err", {7'd0, frame_err}, {7'd0, m_ferr});
                check("cyc_overrun_err", {7'd0, overrun_err}, {7'd0, m_oerr});
                if (m_valid) check("cyc_data", rx_data, m_data);
            end
        end
    end

    // Drives ncyc clocks of a frame (start, 8 data LSB first, stop, then the stop
    // level held), optionally inverting cycles sp_lo..sp_hi and pulsing rx_ready.
    task automatic send(input logic [7:0] b, input logic stop, input int ncyc,
                        input int sp_lo, input int sp_hi, input int ready_at, input int kind);
        logic [9:0] fr;
        logic       lvl;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (i == 0 && kind != EV_NONE) evq.push_back('{cyc + LAT, kind, b});
            lvl = (i < 10 * BITCLK) ? fr[i / BITCLK] : stop;
            rx  = lvl ^ ((i >= sp_lo) && (i <= sp_hi));
            if (i == ready_at)     rx_ready = 1'b1;
            if (i == ready_at + 1) rx_ready = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx = 1'b1;
        end
    endtask

    task automatic pulse_ready();
        @(negedge clk); rx_ready = 1'b1;
        @(negedge clk); rx_ready = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk); clear_err = 1'b1;
        @(negedge clk); clear_err = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rx = 1'b1; rx_ready = 1'b0; clear_err = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_valid", {7'd0, rx_valid}, 8'd0);
        check("reset_data", rx_data, 8'h00);
        check("reset_busy", {7'd0, rx_busy}, 8'd0);
        check("reset_errs", {6'd0, frame_err, overrun_err}, 8'd0);
        reset = 1'b0;
        idle(20);

        // Plain byte, held until the consumer takes it.
        send(8'hA5, 1'b1, 10 * BITCLK, -1, -2, -10, EV_DATA);
        idle(20);
        check("a5_data", rx_data, 8'hA5);
        check("a5_valid", {7'd0, rx_valid}, 8'd1);
        check("a5_errs", {6'd0, frame_err, overrun_err}, 8'd0);
        check("a5_busy", {7'd0, rx_busy}, 8'd0);
        pulse_ready();
        check("a5_consumed", {7'd0, rx_valid}, 8'd0);

        // 40-clock low glitch: brief busy, then silently back to idle.
        send(8'h00, 1'b1, 40, -1, -2, -10, EV_NONE);
        check("glitch_busy", {7'd0, rx_busy}, 8'd1);
        idle(150);
        check("glitch_idle", {7'd0, rx_busy}, 8'd0);
        check("glitch_valid", {7'd0, rx_valid}, 8'd0);
        check("glitch_errs", {6'd0, frame_err, overrun_err}, 8'd0);

        // Bad stop bit followed by a 2000-clock break.
        send(8'h3C, 1'b0, 10 * BITCLK + 2000, -1, -2, -10, EV_FERR);
        check("brk_frame_err", {7'd0, frame_err}, 8'd1);
        check("brk_valid", {7'd0, rx_valid}, 8'd0);
        check("brk_busy", {7'd0, rx_busy}, 8'd1);
        pulse_clear();
        repeat (300) @(negedge clk);
        check("brk_single_err", {7'd0, frame_err}, 8'd0);
        idle(20);
        check("brk_released", {7'd0, rx_busy}, 8'd0);
        send(8'h81, 1'b1, 10 * BITCLK, -1, -2, -10, EV_DATA);
        idle(20);
        check("x81_data", rx_data, 8'h81);
        check("x81_valid", {7'd0, rx_valid}, 8'd1);
        pulse_clear();
        check("x81_frame_err", {7'd0, frame_err}, 8'd0);
        pulse_ready();

        // Back-to-back frames into a full register: overrun.
        send(8'h11, 1'b1, 10 * BITCLK, -1, -2, -10, EV_DATA);
        send(8'h22, 1'b1, 10 * BITCLK, -1, -2, -10, EV_DATA);
        idle(20);
        check("ovr_data", rx_data, 8'h11);
        check("ovr_flag", {7'd0, overrun_err}, 8'd1);
        pulse_clear();
        check("ovr_cleared", {7'd0, overrun_err}, 8'd0);
        // rx_ready high exactly on the delivery edge: reload, no overrun.
        send(8'h33, 1'b1, 10 * BITCLK, -1, -2, LAT - 1, EV_DATA);
        idle(20);
        check("x33_data", rx_data, 8'h33);
        check("x33_valid", {7'd0, rx_valid}, 8'd1);
        check("x33_no_ovr", {7'd0, overrun_err}, 8'd0);
        pulse_ready();

        // One-tick spike centred on bit 3 outvoted by the other two samples.
        send(8'h5A, 1'b1, 10 * BITCLK, 3 * BITCLK + BITCLK / 2 - CPT / 2,
             3 * BITCLK + BITCLK / 2 + CPT / 2 - 1, -10, EV_DATA);
        idle(20);
        check("spike_data", rx_data, 8'h5A);
        check("spike_valid", {7'd0, rx_valid}, 8'd1);

        // Reset in the middle of bit 4 of 0xFF.
        send(8'hFF, 1'b1, 4 * BITCLK + BITCLK / 2, -1, -2, -10, EV_NONE);
        check("pre_rst_busy", {7'd0, rx_busy}, 8'd1);
        @(negedge clk);
        reset = 1'b1;
        rx    = 1'b1;
        #1;
        check("midrst_valid", {7'd0, rx_valid}, 8'd0);
        check("midrst_data", rx_data, 8'h00);
        check("midrst_busy", {7'd0, rx_busy}, 8'd0);
        check("midrst_errs", {6'd0, frame_err, overrun_err}, 8'd0);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        idle(20);
        send(8'h07, 1'b1, 10 * BITCLK, -1, -2, -10, EV_DATA);
        idle(20);
        check("x07_data", rx_data, 8'h07);
        check("x07_valid", {7'd0, rx_valid}, 8'd1);
        check("x07_errs", {6'd0, frame_err, overrun_err}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
